// File: rtl/regarb_pkg.sv
// regarb_pkg: shared widths, arbiter state type and default peripheral register window
package regarb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] WIN_LO_DEF = 5'd23;
  localparam logic [REG_ADDR_W-1:0] WIN_HI_DEF = 5'd27;
  typedef enum logic {NORMAL, STALL} state_e;
endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// regfile_wport_arbiter_if: processor, peripheral and register-file write-port signals
interface regfile_wport_arbiter_if #(parameter int N_PERIPH = 3);
  import regarb_pkg::*;
  logic proc_we;
  logic [REG_ADDR_W-1:0] proc_waddr;
  logic [DATA_W-1:0] proc_wdata;
  logic proc_stall;
  logic [N_PERIPH-1:0] periph_req;
  logic [REG_ADDR_W*N_PERIPH-1:0] periph_waddr;
  logic [DATA_W*N_PERIPH-1:0] periph_wdata;
  logic [N_PERIPH-1:0] periph_ack;
  logic rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic err_window;
  modport master (
    output proc_we, proc_waddr, proc_wdata, periph_req, periph_waddr, periph_wdata,
    input proc_stall, periph_ack, rf_we, rf_waddr, rf_wdata, err_window
  );
  modport slave (
    input proc_we, proc_waddr, proc_wdata, periph_req, periph_waddr, periph_wdata,
    output proc_stall, periph_ack, rf_we, rf_waddr, rf_wdata, err_window
  );
endinterface

// File: rtl/regfile_wport_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first unmasked request after the pointer
module rr_arbiter #(
  parameter int N = 3,
  parameter int IDX_W = 2
) (
  input logic [N-1:0] req_i,
  input logic [N-1:0] mask_i,
  input logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o
);
  logic [N-1:0] elig;
  logic [IDX_W-1:0] j;
  assign elig = req_i & ~mask_i;
  // Scan farthest-to-nearest from the pointer so the nearest eligible requester wins last
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = IDX_W'((int'(ptr_i) + k) % N);
      if (elig[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: shares the register-file write port; optional REGARB_WINDOW_EN restricts peripheral addresses
module regfile_wport_arbiter
  import regarb_pkg::*;
#(
  parameter int N_PERIPH = 3,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W = 4
`ifdef REGARB_WINDOW_EN
  , parameter logic [REG_ADDR_W-1:0] PERIPH_REG_LO = WIN_LO_DEF,
  parameter logic [REG_ADDR_W-1:0] PERIPH_REG_HI = WIN_HI_DEF
`endif
) (
  input logic clock,
  input logic ctrl_reset,
  regfile_wport_arbiter_if.slave bus
);
  localparam int IDX_W = N_PERIPH > 1 ? $clog2(N_PERIPH) : 1;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, idx;
  logic [N_PERIPH-1:0] ack_q, ack_d, gnt;
  logic rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d, pa;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d, pd;
  logic pend, grant, proc_win, starve, bad_win;
  rr_arbiter #(.N(N_PERIPH), .IDX_W(IDX_W)) u_rr (
    .req_i(bus.periph_req),
    .mask_i(ack_q),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(idx)
  );
  // Fetch the winning peripheral's address and data from the packed buses
  always_comb begin
    pa = '0;
    pd = '0;
    for (int i = 0; i < N_PERIPH; i++) begin
      if (gnt[i]) begin
        pa = bus.periph_waddr[i*REG_ADDR_W +: REG_ADDR_W];
        pd = bus.periph_wdata[i*DATA_W +: DATA_W];
      end
    end
  end
  assign pend = |gnt;
  assign proc_win = state_q == NORMAL && bus.proc_we;
  assign grant = pend && !proc_win;
  assign starve = proc_win && pend && cnt_q == CNT_W'(STARVE_LIMIT - 1);
`ifdef REGARB_WINDOW_EN
  logic err_q;
  assign bad_win = pa < PERIPH_REG_LO || pa > PERIPH_REG_HI;
  // Sticky record of any peripheral write that fell outside its register window
  always_ff @(posedge clock) begin
    if (ctrl_reset) err_q <= 1'b0;
    else err_q <= err_q | (grant & bad_win);
  end
  assign bus.err_window = err_q;
`else
  assign bad_win = 1'b0;
  assign bus.err_window = 1'b0;
`endif
  // Next state, starvation count and registered write-port decision
  always_comb begin
    state_d = starve ? STALL : NORMAL;
    cnt_d = (proc_win && pend && !starve) ? cnt_q + 1'b1 : '0;
    ack_d = grant ? gnt : '0;
    ptr_d = grant ? idx : ptr_q;
    rf_we_d = proc_win ? |bus.proc_waddr : grant && |pa && !bad_win;
    rf_waddr_d = proc_win ? bus.proc_waddr : grant ? pa : '0;
    rf_wdata_d = proc_win ? bus.proc_wdata : grant ? pd : '0;
  end
  // State and output registers; reset discards any grant decided this cycle
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_q <= NORMAL;
      cnt_q <= '0;
      ptr_q <= IDX_W'(N_PERIPH - 1);
      ack_q <= '0;
      rf_we_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      ack_q <= ack_d;
      rf_we_q <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end
  assign bus.proc_stall = state_q == STALL;
  assign bus.periph_ack = ack_q;
  assign bus.rf_we = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: scoreboard bench for the register-file write-port arbiter
module tb_regfile_wport_arbiter;
  typedef struct {
    logic [2:0] ack;
    logic we;
    logic [4:0] addr;
    logic [31:0] data;
    logic stall;
    logic err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic exp_err = 1'b0;
  exp_t sb[$];
  regfile_wport_arbiter_if #(.N_PERIPH(3)) bus ();
  regfile_wport_arbiter #(.N_PERIPH(3), .STARVE_LIMIT(8), .CNT_W(4)) dut (
    .clock(clk),
    .ctrl_reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [2:0] ack, input logic we,
                     input logic [4:0] a, input logic [31:0] d, input logic st);
    exp_t e;
    sb.push_back('{ack, we, a, d, st, exp_err});
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check({tag, "_ack"}, 64'(bus.periph_ack), 64'(e.ack));
    check({tag, "_we"}, 64'(bus.rf_we), 64'(e.we));
    check({tag, "_stall"}, 64'(bus.proc_stall), 64'(e.stall));
    check({tag, "_err"}, 64'(bus.err_window), 64'(e.err));
    if (e.we) begin
      check({tag, "_addr"}, 64'(bus.rf_waddr), 64'(e.addr));
      check({tag, "_data"}, 64'(bus.rf_wdata), 64'(e.data));
    end
  endtask
  initial begin
    bus.proc_we = 1'b0;
    bus.proc_waddr = '0;
    bus.proc_wdata = '0;
    bus.periph_req = 3'b000;
    bus.periph_waddr = {5'd25, 5'd24, 5'd23};
    bus.periph_wdata = {32'h102, 32'h101, 32'h100};
    cyc("rst0", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
    cyc("rst1", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
    check("rst_addr", 64'(bus.rf_waddr), 64'd0);
    check("rst_data", 64'(bus.rf_wdata), 64'd0);
    rst = 1'b0;
    bus.proc_we = 1'b1;
    bus.proc_waddr = 5'd5;
    bus.proc_wdata = 32'hDEADBEEF;
    cyc("proc", 3'b000, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    bus.proc_we = 1'b0;
    cyc("idle", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
    bus.periph_req = 3'b111;
    cyc("rr0", 3'b001, 1'b1, 5'd23, 32'h100, 1'b0);
    cyc("rr1", 3'b010, 1'b1, 5'd24, 32'h101, 1'b0);
    cyc("rr2", 3'b100, 1'b1, 5'd25, 32'h102, 1'b0);
    cyc("rr3", 3'b001, 1'b1, 5'd23, 32'h100, 1'b0);
    bus.periph_req = 3'b000;
    cyc("rr_idle", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
    bus.proc_we = 1'b1;
    bus.proc_waddr = 5'd7;
    bus.proc_wdata = 32'h77;
    bus.periph_req = 3'b010;
    for (int i = 1; i <= 7; i++) cyc("starve", 3'b000, 1'b1, 5'd7, 32'h77, 1'b0);
    cyc("starve8", 3'b000, 1'b1, 5'd7, 32'h77, 1'b1);
    cyc("stall_gnt", 3'b010, 1'b1, 5'd24, 32'h101, 1'b0);
    bus.periph_req = 3'b000;
    cyc("resume", 3'b000, 1'b1, 5'd7, 32'h77, 1'b0);
    bus.proc_we = 1'b0;
    bus.periph_waddr[14:10] = 5'd0;
    bus.periph_wdata[95:64] = 32'h1234;
    bus.periph_req = 3'b100;
`ifdef REGARB_WINDOW_EN
    exp_err = 1'b1;
`endif
    cyc("p2_r0", 3'b100, 1'b0, 5'd0, 32'd0, 1'b0);
    bus.periph_req = 3'b000;
    bus.proc_we = 1'b1;
    bus.proc_waddr = 5'd0;
    cyc("proc_r0", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
    bus.proc_we = 1'b0;
    bus.periph_waddr[14:10] = 5'd25;
    bus.periph_wdata[95:64] = 32'h102;
    bus.periph_req = 3'b110;
    cyc("pre_rst", 3'b010, 1'b1, 5'd24, 32'h101, 1'b0);
    bus.periph_req = 3'b101;
    rst = 1'b1;
    exp_err = 1'b0;
    cyc("mid_rst", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
    rst = 1'b0;
    cyc("post_rst", 3'b001, 1'b1, 5'd23, 32'h100, 1'b0);
    bus.periph_req = 3'b100;
    cyc("post_rst2", 3'b100, 1'b1, 5'd25, 32'h102, 1'b0);
    bus.periph_req = 3'b000;
    cyc("post_idle", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
`ifdef REGARB_WINDOW_EN
    bus.periph_waddr[4:0] = 5'd18;
    bus.periph_req = 3'b001;
    exp_err = 1'b1;
    cyc("win_bad", 3'b001, 1'b0, 5'd0, 32'd0, 1'b0);
    bus.periph_req = 3'b000;
    cyc("win_hold", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
    bus.periph_waddr[4:0] = 5'd23;
    bus.periph_req = 3'b001;
    cyc("win_ok", 3'b001, 1'b1, 5'd23, 32'h100, 1'b0);
    bus.periph_req = 3'b000;
    rst = 1'b1;
    exp_err = 1'b0;
    cyc("win_rst", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
    rst = 1'b0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the register file's single write port between processor writeback and N peripheral writers, e.g. shape-button capture and motor status.
- Processor writes have priority. Peripherals are served round-robin in idle write slots.
- A starvation guard stalls the processor for one cycle so that a waiting peripheral is guaranteed service.
- Sits between the processor writeback stage, the peripherals and the register file write inputs.

Parameters:
- N_PERIPH, 3, number of peripheral requesters (1..8).
- STARVE_LIMIT, 8, consecutive processor-won cycles with a peripheral pending before a forced stall.
- CNT_W, 4, starvation counter width; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clock  in  1  system clock, rising edge.
- ctrl_reset  in  1  synchronous, active-high reset.
- proc_we  in  1  processor write request.
- proc_waddr  in  5  processor destination register.
- proc_wdata  in  32  processor write data.
- proc_stall  out  1  processor must hold its writeback this cycle.
- periph_req  in  N_PERIPH  per-peripheral request; held until ack.
- periph_waddr  in  5*N_PERIPH  packed addresses; peripheral i uses bits [5i+4:5i].
- periph_wdata  in  32*N_PERIPH  packed data; peripheral i uses bits [32i+31:32i].
- periph_ack  out  N_PERIPH  one-cycle pulse: transfer accepted.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- err_window  out  1  sticky illegal-address flag (optional feature only).

Behaviour:
- Clock and reset: single clock, clock. ctrl_reset is synchronous and active-high. On reset:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - periph_ack=0, proc_stall=0, err_window=0.
  - State=NORMAL, starvation counter=0, round-robin pointer=N_PERIPH-1, so peripheral 0 is searched first.
- Outputs: rf_*, periph_ack and err_window are registered. The grant decision at cycle t appears at t+1, so a write reaches the register file 1 cycle after grant.
- proc_stall is a Moore output of state: 1 only in STALL.
- NORMAL state:
  - If proc_we=1, the processor wins. Its write is issued at t+1 and no peripheral is acked.
  - Else, if any eligible periph_req is high, the round-robin winner is granted. The search starts at pointer+1 and wraps at N_PERIPH-1→0. The pointer is updated to the winner.
  - Eligible = req high AND its periph_ack is not high this cycle. This masking prevents a double grant of a held request.
- Starvation counter:
  - Increments when proc_we=1 and any eligible request is pending.
  - Clears on any peripheral grant, or when no request is pending.
  - When the counter reaches STARVE_LIMIT in a cycle where the processor wins, next state=STALL and the counter clears.
- STALL state (exactly 1 cycle):
  - proc_stall=1. proc_we is ignored; the processor re-presents its write later.
  - The round-robin winner is granted. If no request remains, the slot is empty.
  - Next state=NORMAL.
- Register 0: a write to address 0 from any source produces rf_we=0 at t+1. A peripheral making such a write is still acked and the pointer still advances.
- Reset mid-operation: a pending grant is discarded. No ack and no write is issued.
- Peripheral contract: req, waddr and wdata stay stable from assertion until the ack cycle. Req may remain high after ack to request the next transfer.

Optional Feature:
- Macro: REGARB_WINDOW_EN.
- Defined:
  - Adds parameters PERIPH_REG_LO (default 23) and PERIPH_REG_HI (default 27).
  - A peripheral write outside [LO,HI] is acked but not written (rf_we=0).
  - err_window is set at t+1 and stays set until ctrl_reset.
- Undefined:
  - err_window is tied 0.
  - Peripherals may write any register except 0.
- Processor writes are never window-checked.

Decomposition:
- Package regarb_pkg:
  - REG_ADDR_W=5, DATA_W=32.
  - State enum {NORMAL, STALL}.
  - Default window bounds.
- Sub-module rr_arbiter:
  - Inputs: req vector, mask, pointer.
  - Outputs: one-hot grant and winner index.
  - Pure combinational; the pointer register lives in the parent.

Test Plan:
- Processor write only: proc_we=1, waddr=5, wdata=0xDEADBEEF at t → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at t+1. No ack.
- Round-robin: all three periph_req held high, proc_we=0, addresses 23/24/25 → acks in order 0,1,2,0 on successive grants. No peripheral is acked in back-to-back cycles while others are pending.
- Starvation: proc_we=1 continuously, periph_req[1]=1:
  - proc_stall=1 exactly once, after 8 processor-won cycles.
  - periph_ack[1] pulses on the cycle after the stall.
  - The processor write resumes.
- Register 0: peripheral 2 writes address 0 with data 0x1234 → periph_ack[2]=1, rf_we=0. The processor then writes address 0 → rf_we=0.
- Reset: ctrl_reset asserted in the cycle a peripheral is granted → next cycle ack=0, rf_we=0, and the pointer returns to reset value, so peripheral 0 is served first afterwards.
- Window (REGARB_WINDOW_EN): peripheral 0 writes address 18 → acked, rf_we=0, err_window=1 and held through later legal writes until ctrl_reset.
